// File: rtl/ps2_keycode_fifo.sv
// PS/2 set-2 keycode front end: prefix decoder, programmable remap table and
// first-word-fall-through event FIFO between PS2_Controller and software.
module ps2_keycode_fifo #(
    parameter int ADDR_W = 3,
    parameter int IDX_W  = 2
) (
    input  logic              inclock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              map_we,
    input  logic [IDX_W-1:0]  map_idx,
    input  logic [7:0]        map_from,
    input  logic [7:0]        map_to,
    input  logic              pop,
    output logic              ev_valid,
    output logic [7:0]        ev_code,
    output logic              ev_break,
    output logic              ev_ext,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        last_data_received
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int NUM_MAP = 1 << IDX_W;
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Controller status/ack bytes that never form part of a key sequence.
    function automatic logic is_status(input logic [7:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Default keypad remap entry {valid, from, to} for a table index.
    function automatic logic [16:0] default_entry(input int idx);
        logic [16:0] e;
        case (idx)
            32'sd0:  e = {1'b1, 8'h15, 8'h51};
            32'sd1:  e = {1'b1, 8'h2D, 8'h52};
            32'sd2:  e = {1'b1, 8'h1B, 8'h53};
            32'sd3:  e = {1'b1, 8'h2C, 8'h54};
            default: e = 17'd0;
        endcase
        return e;
    endfunction

    state_t            state_q, state_d;
    logic              map_vld_q  [NUM_MAP];
    logic [7:0]        map_from_q [NUM_MAP];
    logic [7:0]        map_to_q   [NUM_MAP];
    logic [9:0]        mem_q      [DEPTH];    // {ext, break, code}
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        last_q, last_d;

    logic              emit_s;
    logic              ev_brk_s;
    logic              ev_ext_s;
    logic [7:0]        mapped_s;
    logic              full_s;
    logic              do_pop_s;
    logic              do_push_s;
    logic              drop_s;
    logic [9:0]        head_s;

    // Prefix decoder: next state and event emission on each received byte.
    always_comb begin
        state_d  = state_q;
        emit_s   = 1'b0;
        ev_brk_s = 1'b0;
        ev_ext_s = 1'b0;
        if (rx_valid) begin
            if (is_status(rx_data)) begin
                state_d = ST_IDLE;
            end else if (rx_data == 8'hE0) begin
                state_d = ST_EXT;
            end else if (rx_data == 8'hF0) begin
                case (state_q)
                    ST_IDLE:    state_d = ST_BRK;
                    ST_EXT:     state_d = ST_EXT_BRK;
                    ST_BRK:     state_d = ST_BRK;
                    ST_EXT_BRK: state_d = ST_EXT_BRK;
                    default:    state_d = ST_IDLE;
                endcase
            end else begin
                emit_s   = 1'b1;
                ev_brk_s = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                ev_ext_s = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                state_d  = ST_IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Remap lookup; scanning high to low lets the lowest matching index win.
    always_comb begin
        mapped_s = rx_data;
        for (int i = NUM_MAP - 1; i >= 0; i--) begin
            mapped_s = (map_vld_q[i] && (map_from_q[i] == rx_data)) ? map_to_q[i] : mapped_s;
        end
    end

    // FIFO bookkeeping: a pop while full frees the slot for a same-cycle push.
    always_comb begin
        full_s     = (count_q == FULL_CNT);
        do_pop_s   = pop && (count_q != '0);
        do_push_s  = emit_s && (!full_s || do_pop_s);
        drop_s     = emit_s && full_s && !do_pop_s;
        wr_ptr_d   = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        overflow_d = overflow_q | drop_s;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (emit_s && !ev_brk_s) begin
            last_d = mapped_s;
        end else begin
            last_d = last_q;
        end
    end

    // Control state, pointers, status and remap table with synchronous reset.
    always_ff @(posedge inclock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= 8'h00;
            for (int i = 0; i < NUM_MAP; i++) begin
                {map_vld_q[i], map_from_q[i], map_to_q[i]} <= default_entry(i);
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
            if (map_we) begin
                map_vld_q[map_idx]  <= 1'b1;
                map_from_q[map_idx] <= map_from;
                map_to_q[map_idx]   <= map_to;
            end else begin
                map_vld_q[map_idx]  <= map_vld_q[map_idx];
            end
        end
    end

    // Event storage; contents need no reset because count gates visibility.
    always_ff @(posedge inclock) begin
        if (!reset && do_push_s) begin
            mem_q[wr_ptr_q] <= {ev_ext_s, ev_brk_s, mapped_s};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Head-of-queue view, forced to zero while the FIFO is empty.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (count_q != '0) begin
            ev_valid = 1'b1;
            ev_code  = head_s[7:0];
            ev_break = head_s[8];
            ev_ext   = head_s[9];
        end else begin
            ev_valid = 1'b0;
            ev_code  = 8'h00;
            ev_break = 1'b0;
            ev_ext   = 1'b0;
        end
    end

    assign count              = count_q;
    assign overflow           = overflow_q;
    assign last_data_received = last_q;

endmodule

// File: tb/tb_ps2_keycode_fifo.sv
// Directed scoreboard bench for ps2_keycode_fifo.
module tb_ps2_keycode_fifo;

    localparam int ADDR_W = 3;
    localparam int IDX_W  = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              inclock = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              map_we;
    logic [IDX_W-1:0]  map_idx;
    logic [7:0]        map_from;
    logic [7:0]        map_to;
    logic              pop;
    logic              ev_valid;
    logic [7:0]        ev_code;
    logic              ev_break;
    logic              ev_ext;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        last_data_received;

    ps2_keycode_fifo #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .inclock(inclock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .map_we(map_we), .map_idx(map_idx), .map_from(map_from), .map_to(map_to),
        .pop(pop), .ev_valid(ev_valid), .ev_code(ev_code), .ev_break(ev_break),
        .ev_ext(ev_ext), .count(count), .overflow(overflow),
        .last_data_received(last_data_received)
    );

    always #5 inclock = ~inclock;

    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         total_cnt = 0;
    logic [9:0] exp_q[$];        // {ext, break, code}
    logic       ovf_m = 1'b0;
    logic [7:0] last_m = 8'h00;

    // pending table write applied in the same cycle as the next step
    logic             pend_we = 1'b0;
    logic [IDX_W-1:0] pend_idx = '0;
    logic [7:0]       pend_from = 8'h00;
    logic [7:0]       pend_to = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, " ev_valid"}, 32'(ev_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk({tag, " ev_code"}, 32'(ev_code), 32'(exp_q[0][7:0]));
            chk({tag, " ev_break"}, 32'(ev_break), 32'(exp_q[0][8]));
            chk({tag, " ev_ext"}, 32'(ev_ext), 32'(exp_q[0][9]));
        end else begin
            chk({tag, " ev_code_empty"}, 32'(ev_code), 32'h0);
        end
        chk({tag, " overflow"}, 32'(overflow), 32'(ovf_m));
        chk({tag, " last"}, 32'(last_data_received), 32'(last_m));
    endtask

    // One clock of stimulus; emit/code/brk/ext describe the event this byte should yield.
    task automatic step(input string tag, input logic [7:0] b, input logic v, input logic p,
                        input logic emit, input logic [7:0] code, input logic brk, input logic ext);
        @(negedge inclock);
        rx_data  = b;
        rx_valid = v;
        pop      = p;
        map_we   = pend_we;
        map_idx  = pend_idx;
        map_from = pend_from;
        map_to   = pend_to;
        if (p && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        if (emit) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({ext, brk, code});
            else ovf_m = 1'b1;
            if (!brk) last_m = code;
        end
        @(negedge inclock);
        rx_valid = 1'b0;
        pop      = 1'b0;
        map_we   = 1'b0;
        pend_we  = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge inclock);
        reset    = 1'b1;
        rx_data  = 8'h15;   // activity during reset must be ignored
        rx_valid = 1'b1;
        pop      = 1'b1;
        map_we   = 1'b1;
        map_idx  = '0;
        map_from = 8'h15;
        map_to   = 8'h77;
        @(negedge inclock);
        reset    = 1'b0;
        rx_valid = 1'b0;
        pop      = 1'b0;
        map_we   = 1'b0;
        exp_q.delete();
        ovf_m  = 1'b0;
        last_m = 8'h00;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; pop = 1'b0;
        map_we = 1'b0; map_idx = '0; map_from = 8'h00; map_to = 8'h00;
        repeat (2) @(posedge inclock);
        do_reset("reset");

        // default remap of a make code
        step("make15", 8'h15, 1'b1, 1'b0, 1'b1, 8'h51, 1'b0, 1'b0);
        step("pop15",  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("pop_empty", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // extended break
        step("e0",  8'hE0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("f0",  8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("x75", 8'h75, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1);
        step("pop75", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // plain break, remapped
        step("f0b", 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("b1b", 8'h1B, 1'b1, 1'b0, 1'b1, 8'h53, 1'b1, 1'b0);
        step("pop1b", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // status filtering and prefix abort
        step("fa",  8'hFA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("e0s", 8'hE0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("aa",  8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("m1c", 8'h1C, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0);
        step("pop1c", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // fill past capacity: ninth code dropped but still sets last
        for (int i = 0; i < DEPTH + 1; i++) begin
            step($sformatf("fill%0d", i), 8'h20 + 8'(i), 1'b1, 1'b0, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        end
        // push and pop together while full
        step("full_pp", 8'h30, 1'b1, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step($sformatf("drain%0d", i), 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // table write in same cycle as lookup sees old contents
        pend_we = 1'b1; pend_idx = 2'd1; pend_from = 8'h2D; pend_to = 8'h99;
        step("map_same", 8'h2D, 1'b1, 1'b0, 1'b1, 8'h52, 1'b0, 1'b0);
        step("map_new",  8'h2D, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        pend_we = 1'b1; pend_idx = 2'd0; pend_from = 8'h99; pend_to = 8'h11;
        step("map_w0",   8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("map_single", 8'h2D, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        step("map_99",   8'h99, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("mdrain%0d", i), 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // reset mid-operation discards queue, prefix and table edits
        step("r1c", 8'h1C, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0);
        step("r2c", 8'h2C, 1'b1, 1'b0, 1'b1, 8'h54, 1'b0, 1'b0);
        step("r33", 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        step("re0", 8'hE0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset("midreset");
        step("post75", 8'h75, 1'b1, 1'b0, 1'b1, 8'h75, 1'b0, 1'b0);
        step("post15", 8'h15, 1'b1, 1'b0, 1'b1, 8'h51, 1'b0, 1'b0);
        step("post2d", 8'h2D, 1'b1, 1'b0, 1'b1, 8'h52, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_fifo.md
Name: ps2_keycode_fifo

Overview:
- Sits between PS2_Controller (byte stream `received_data` / `received_data_en`) and the processor or IO logic.
- Decodes PS/2 set-2 prefix sequences into make/break/extended key events.
- Remaps key codes through a small programmable table, loaded at reset with the team's default keypad remap.
- Buffers events in a parametrised first-word-fall-through FIFO, so bursts of keystrokes are not lost between software polls.

Parameters:
- ADDR_W, 3: FIFO address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1).
- IDX_W, 2: remap-table index width; NUM_MAP = 2**IDX_W entries.

Ports:
- inclock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from PS2_Controller.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- map_we  in  1  remap-table write strobe.
- map_idx  in  IDX_W  table entry to write.
- map_from  in  8  code to match.
- map_to  in  8  replacement code.
- pop  in  1  consume head event.
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  8  head event code (remapped).
- ev_break  out  1  head event is a key release.
- ev_ext  out  1  head event carried an E0 prefix.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky, an event was dropped.
- last_data_received  out  8  most recent make code (remapped).

Behaviour:
- Reset (reset=1 at posedge):
  - FSM goes to IDLE; FIFO is emptied.
  - count=0, ev_valid=0, overflow=0, last_data_received=8'h00.
  - ev_code/ev_break/ev_ext are don't-care while empty; drive 0.
  - Table entries 0..3 load 15->51, 2D->52, 1B->53, 2C->54 (only those with index < NUM_MAP). Any remaining entries are invalid.
  - rx_valid, map_we and pop are ignored in the reset cycle.
  - A reset mid-prefix discards the partial sequence.
- Decoder FSM, advancing only on rx_valid. States: IDLE, EXT, BRK, EXT_BRK.
  - Status bytes 00, AA, EE, FA, FC, FD, FE, FF: discarded in any state; FSM returns to IDLE; no event.
  - E0 in any state: go to EXT (clears any pending break).
  - F0: IDLE->BRK, EXT->EXT_BRK, BRK->BRK, EXT_BRK->EXT_BRK.
  - Any other byte: emit event {code=rx_data, break=(BRK|EXT_BRK), ext=(EXT|EXT_BRK)}; FSM goes to IDLE.
- Remap:
  - Applied combinationally to the emitted code.
  - Lowest-index valid entry with map_from==code wins; if none matches, the code passes through unchanged.
  - map_we writes entry map_idx = {valid=1, map_from, map_to}, effective from the next cycle. A same-cycle lookup uses the old contents.
- Latency: event for the byte strobed at cycle t is visible on ev_* / count at t+1, if the FIFO was empty.
- last_data_received:
  - Updates at t+1 with the remapped code on make events only.
  - Updates even if the FIFO drops the event.
  - Break events never update it.
- FIFO:
  - Push happens on emit. Pop happens when pop && ev_valid; pop while empty is ignored.
  - Simultaneous push and pop: both occur; count unchanged. This also holds when full: the pop frees the slot and the push succeeds.
  - Push while full without pop: event dropped, overflow set to 1. overflow clears only on reset.
  - Pointers wrap modulo DEPTH.
  - ev_* always show the head entry (first-word fall-through) and change the cycle after a pop.

Test Plan:
- Default remap: rx bytes 15 -> one event {51, break=0, ext=0} at t+1; last_data_received=51; count=1.
- Break/extended sequences:
  - E0,F0,75 -> single event {75, break=1, ext=1}; last_data_received unchanged.
  - F0,1B -> {53, break=1, ext=0}.
- Status filtering: FA, then E0, AA, 1C -> FA produces no event; AA aborts the prefix; 1C emits {1C, ext=0}; count=1.
- Overflow: ADDR_W=3, push 9 make codes with no pop -> count=8, overflow=1, 9th code lost, but last_data_received equals the 9th code. Then push and pop in the same cycle while full -> count stays 8, new code stored at the tail.
- Programming the table: map_we idx=1 {2D->99} in the same cycle as the last byte of code 2D -> that event reads 52 (old contents). Next 2D -> 99. Write idx=0 {99->11}, then send 2D -> 99, because the lookup is single-level.
- Reset mid-operation: after E0 and 3 queued events, assert reset -> count=0, overflow=0, last=00, table restored. Next byte 75 -> {75, ext=0}.
